// File: rtl/pitch_pkg.sv
// Shared encodings and helpers for the pitch-estimator front end
// (frame writer and its bank tracker).
package pitch_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 11;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_FILL  = 2'd1,
    WR_STALL = 2'd2
  } wr_state_t;

  // Ceiling log2, floored at 1 so a bank index is never zero bits wide.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/frame_bank_tracker.sv
// Per-bank FREE/FILLING/FULL bookkeeping plus the oldest-first handoff of full
// frames to the consumer.
module frame_bank_tracker
  import pitch_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_fill,
  input  logic [BANK_W-1:0]    start_idx,
  input  logic                 commit,
  input  logic [BANK_W-1:0]    commit_idx,
  input  logic                 abort,
  input  logic [BANK_W-1:0]    abort_idx,
  input  logic                 frame_ready,
  output logic [NUM_BANKS-1:0] free_vec,
  output logic                 frame_valid,
  output logic [BANK_W-1:0]    frame_bank
);

  logic [BANK_W-1:0]    head_reg;
  logic [NUM_BANKS-1:0] full_vec;
  logic                 release_fire;

  assign frame_valid  = full_vec[head_reg];
  assign frame_bank   = head_reg;
  assign release_fire = frame_valid & frame_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      bank_state_t state_reg;

      // Release and commit never target the same bank: only the head can be
      // released and it is already FULL, whereas commit hits a FILLING bank.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= BANK_FREE;
        end else if (release_fire && head_reg == BANK_W'(gi)) begin
          state_reg <= BANK_FREE;
        end else if (commit && commit_idx == BANK_W'(gi)) begin
          state_reg <= BANK_FULL;
        end else if (start_fill && start_idx == BANK_W'(gi)) begin
          state_reg <= BANK_FILLING;
        end else if (abort && abort_idx == BANK_W'(gi)) begin
          state_reg <= BANK_FREE;
        end
      end

      assign free_vec[gi] = (state_reg == BANK_FREE);
      assign full_vec[gi] = (state_reg == BANK_FULL);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= '0;
    end else if (release_fire) begin
      head_reg <= (head_reg == BANK_W'(NUM_BANKS - 1)) ? '0 : head_reg + BANK_W'(1);
    end
  end

endmodule

// File: rtl/multibank_frame_writer.sv
// Captures ADC samples into NUM_BANKS round-robin frame buffers and hands
// completed frames to the pitch estimator via frame_valid/frame_ready.
module multibank_frame_writer
  import pitch_pkg::*;
#(
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  ADDR_W    = DEF_ADDR_W,
  parameter int  NUM_BANKS = 2,
  parameter int  CNT_W     = 16,
  localparam int BANK_W    = clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    frame_len_m1,
  input  logic                 sample_tick,
  input  logic [DATA_W-1:0]    data,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 frame_valid,
  output logic [BANK_W-1:0]    frame_bank,
  input  logic                 frame_ready,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     overrun_cnt
);

  wr_state_t            state_reg, state_next;
  logic [BANK_W-1:0]    cur_reg, cur_next, nxt_bank;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [ADDR_W-1:0]    len_reg, len_next;
  logic [NUM_BANKS-1:0] wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]    wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0]    wr_data_reg, wr_data_next;
  logic                 done_reg, done_next;
  logic [CNT_W-1:0]     drop_reg, ovr_reg;
  logic                 drop_inc, ovr_inc;
  logic                 start_fill, commit, abort;
  logic [BANK_W-1:0]    start_idx;
  logic [NUM_BANKS-1:0] free_vec;

  frame_bank_tracker #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .start_fill  (start_fill),
    .start_idx   (start_idx),
    .commit      (commit),
    .commit_idx  (cur_reg),
    .abort       (abort),
    .abort_idx   (cur_reg),
    .frame_ready (frame_ready),
    .free_vec    (free_vec),
    .frame_valid (frame_valid),
    .frame_bank  (frame_bank)
  );

  assign nxt_bank = (cur_reg == BANK_W'(NUM_BANKS - 1)) ? '0 : cur_reg + BANK_W'(1);

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    addr_next    = addr_reg;
    len_next     = len_reg;
    wr_en_next   = '0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    done_next    = 1'b0;
    drop_inc     = 1'b0;
    ovr_inc      = 1'b0;
    start_fill   = 1'b0;
    start_idx    = cur_reg;
    commit       = 1'b0;
    abort        = 1'b0;

    case (state_reg)
      WR_IDLE: begin
        if (run && free_vec[cur_reg]) begin
          state_next = WR_FILL;
          start_fill = 1'b1;
          addr_next  = '0;
          len_next   = frame_len_m1;
        end
      end

      WR_FILL: begin
        if (!run) begin
          abort      = 1'b1;
          addr_next  = '0;
          state_next = WR_IDLE;
        end else if (sample_tick) begin
          wr_en_next[cur_reg] = 1'b1;
          wr_addr_next        = addr_reg;
          wr_data_next        = data;
          if (addr_reg == len_reg) begin
            addr_next = '0;
            if (free_vec[nxt_bank]) begin
              commit     = 1'b1;
              done_next  = 1'b1;
              cur_next   = nxt_bank;
              start_fill = 1'b1;
              start_idx  = nxt_bank;
              len_next   = frame_len_m1;
            end else if (mode) begin
              // Overwrite: discard this frame and refill the same bank.
              ovr_inc  = 1'b1;
              len_next = frame_len_m1;
            end else begin
              commit     = 1'b1;
              done_next  = 1'b1;
              cur_next   = nxt_bank;
              state_next = WR_STALL;
            end
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
          end
        end
      end

      WR_STALL: begin
        if (!run) begin
          state_next = WR_IDLE;
        end else begin
          drop_inc = sample_tick;
          if (free_vec[cur_reg]) begin
            state_next = WR_FILL;
            start_fill = 1'b1;
            addr_next  = '0;
            len_next   = frame_len_m1;
          end
        end
      end

      default: state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= WR_IDLE;
      cur_reg     <= '0;
      addr_reg    <= '0;
      len_reg     <= '0;
      wr_en_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      done_reg    <= 1'b0;
      drop_reg    <= '0;
      ovr_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      done_reg    <= done_next;
      if (drop_inc && drop_reg != '1) drop_reg <= drop_reg + CNT_W'(1);
      if (ovr_inc && ovr_reg != '1) ovr_reg <= ovr_reg + CNT_W'(1);
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign frame_done  = done_reg;
  assign drop_cnt    = drop_reg;
  assign overrun_cnt = ovr_reg;

endmodule

// File: tb/tb_multibank_frame_writer.sv
// Directed bench for multibank_frame_writer: a 2-bank and a 4-bank instance
// share stimulus; each scenario task checks its own expected values.
module tb_multibank_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        mode = 1'b0;
  logic [10:0] frame_len_m1 = '0;
  logic        sample_tick = 1'b0;
  logic [11:0] data = '0;
  logic        frame_ready = 1'b0;

  logic [1:0]  wr_en;
  logic [10:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_valid;
  logic [0:0]  frame_bank;
  logic        frame_done;
  logic [15:0] drop_cnt, overrun_cnt;

  logic [3:0]  wr_en_4;
  logic [10:0] wr_addr_4;
  logic [11:0] wr_data_4;
  logic        frame_valid_4;
  logic [1:0]  frame_bank_4;
  logic        frame_done_4;
  logic [15:0] drop_cnt_4, overrun_cnt_4;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  multibank_frame_writer #(.DATA_W(12), .ADDR_W(11), .NUM_BANKS(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .frame_len_m1(frame_len_m1),
    .sample_tick(sample_tick), .data(data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_valid(frame_valid), .frame_bank(frame_bank),
    .frame_ready(frame_ready), .frame_done(frame_done), .drop_cnt(drop_cnt),
    .overrun_cnt(overrun_cnt)
  );

  multibank_frame_writer #(.DATA_W(12), .ADDR_W(11), .NUM_BANKS(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .frame_len_m1(frame_len_m1),
    .sample_tick(sample_tick), .data(data), .wr_en(wr_en_4), .wr_addr(wr_addr_4),
    .wr_data(wr_data_4), .frame_valid(frame_valid_4), .frame_bank(frame_bank_4),
    .frame_ready(frame_ready), .frame_done(frame_done_4), .drop_cnt(drop_cnt_4),
    .overrun_cnt(overrun_cnt_4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic [11:0] d);
    sample_tick = 1'b1;
    data = d;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; run = 1'b0; mode = 1'b0; sample_tick = 1'b0;
    frame_ready = 1'b0; data = '0; frame_len_m1 = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    vec_cnt++;
    if ({wr_en, wr_addr, wr_data, frame_valid, frame_bank, frame_done, drop_cnt, overrun_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL reset_nb2: got en=%b addr=%h data=%h v=%b b=%h d=%b drop=%h ovr=%h, expected all 0",
               wr_en, wr_addr, wr_data, frame_valid, frame_bank, frame_done, drop_cnt, overrun_cnt);
    end
    vec_cnt++;
    if ({wr_en_4, wr_addr_4, wr_data_4, frame_valid_4, frame_bank_4, frame_done_4, drop_cnt_4, overrun_cnt_4} !== '0) begin
      err_cnt++;
      $display("FAIL reset_nb4: got en=%b addr=%h data=%h v=%b b=%h d=%b drop=%h ovr=%h, expected all 0",
               wr_en_4, wr_addr_4, wr_data_4, frame_valid_4, frame_bank_4, frame_done_4, drop_cnt_4, overrun_cnt_4);
    end
    $display("test_reset done: vectors=%0d", vec_cnt);
  endtask

  task automatic test_round_robin();
    int done_seen;
    logic [1:0] exp_en;
    apply_reset();
    frame_len_m1 = 11'd7; frame_ready = 1'b1; run = 1'b1;
    step();
    done_seen = 0;
    for (int i = 0; i < 16; i++) begin
      exp_en = (i < 8) ? 2'b01 : 2'b10;
      do_tick(12'(256 + i));
      vec_cnt++;
      if (wr_en !== exp_en || wr_addr !== 11'(i % 8) || wr_data !== 12'(256 + i) ||
          frame_done !== ((i % 8) == 7)) begin
        err_cnt++;
        $display("FAIL rr_write[%0d]: got en=%b addr=%0d data=%h done=%b, expected en=%b addr=%0d data=%h done=%b",
                 i, wr_en, wr_addr, wr_data, frame_done, exp_en, i % 8, 12'(256 + i), (i % 8) == 7);
      end
      if (frame_done === 1'b1) begin
        done_seen++;
        vec_cnt++;
        if (frame_valid !== 1'b1 || frame_bank !== 1'(i / 8)) begin
          err_cnt++;
          $display("FAIL rr_handoff[%0d]: got valid=%b bank=%0d, expected valid=1 bank=%0d",
                   i, frame_valid, frame_bank, i / 8);
        end
      end
      step();
      vec_cnt++;
      if (wr_en !== 2'b00) begin
        err_cnt++;
        $display("FAIL rr_single_pulse[%0d]: got en=%b, expected 00", i, wr_en);
      end
    end
    vec_cnt++;
    if (done_seen != 2 || drop_cnt !== 16'd0) begin
      err_cnt++;
      $display("FAIL rr_totals: got done=%0d drop=%0d, expected done=2 drop=0", done_seen, drop_cnt);
    end
    $display("test_round_robin done: vectors=%0d", vec_cnt);
  endtask

  task automatic test_stall();
    logic [1:0] exp_en;
    apply_reset();
    frame_len_m1 = 11'd3; run = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      exp_en = (i < 4) ? 2'b01 : ((i < 8) ? 2'b10 : 2'b00);
      do_tick(12'(i + 1));
      vec_cnt++;
      if (wr_en !== exp_en || (i < 8 && wr_addr !== 11'(i % 4))) begin
        err_cnt++;
        $display("FAIL stall_write[%0d]: got en=%b addr=%0d, expected en=%b addr=%0d",
                 i, wr_en, wr_addr, exp_en, i % 4);
      end
      step();
    end
    vec_cnt++;
    if (drop_cnt !== 16'd4 || overrun_cnt !== 16'd0 || frame_valid !== 1'b1 || frame_bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_state: got drop=%0d ovr=%0d valid=%b bank=%0d, expected drop=4 ovr=0 valid=1 bank=0",
               drop_cnt, overrun_cnt, frame_valid, frame_bank);
    end
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    vec_cnt++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_release: got valid=%b bank=%0d, expected valid=1 bank=1", frame_valid, frame_bank);
    end
    step();
    do_tick(12'hABC);
    vec_cnt++;
    if (wr_en !== 2'b01 || wr_addr !== 11'd0 || wr_data !== 12'hABC || drop_cnt !== 16'd4) begin
      err_cnt++;
      $display("FAIL stall_resume: got en=%b addr=%0d data=%h drop=%0d, expected en=01 addr=0 data=abc drop=4",
               wr_en, wr_addr, wr_data, drop_cnt);
    end
    $display("test_stall done: vectors=%0d", vec_cnt);
  endtask

  task automatic test_overwrite();
    logic [1:0]  exp_en;
    logic [15:0] exp_ovr;
    apply_reset();
    frame_len_m1 = 11'd3; mode = 1'b1; run = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      exp_en  = (i < 4) ? 2'b01 : 2'b10;
      exp_ovr = 16'((i >= 7) ? 1 : 0) + 16'((i >= 11) ? 1 : 0);
      do_tick(12'(16 + i));
      vec_cnt++;
      if (wr_en !== exp_en || wr_addr !== 11'(i % 4) || frame_done !== (i == 3) || overrun_cnt !== exp_ovr) begin
        err_cnt++;
        $display("FAIL ovr_write[%0d]: got en=%b addr=%0d done=%b ovr=%0d, expected en=%b addr=%0d done=%b ovr=%0d",
                 i, wr_en, wr_addr, frame_done, overrun_cnt, exp_en, i % 4, i == 3, exp_ovr);
      end
      step();
    end
    vec_cnt++;
    if (drop_cnt !== 16'd0 || frame_valid !== 1'b1 || frame_bank !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovr_state: got drop=%0d valid=%b bank=%0d, expected drop=0 valid=1 bank=0",
               drop_cnt, frame_valid, frame_bank);
    end
    $display("test_overwrite done: vectors=%0d", vec_cnt);
  endtask

  task automatic test_four_banks();
    apply_reset();
    frame_len_m1 = 11'd0; run = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      do_tick(12'(48 + i));
      vec_cnt++;
      if (wr_en_4 !== 4'(1 << i) || wr_addr_4 !== 11'd0 || frame_done_4 !== 1'b1) begin
        err_cnt++;
        $display("FAIL nb4_write[%0d]: got en=%b addr=%0d done=%b, expected en=%b addr=0 done=1",
                 i, wr_en_4, wr_addr_4, frame_done_4, 4'(1 << i));
      end
      step();
    end
    frame_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if (frame_valid_4 !== 1'b1 || frame_bank_4 !== 2'(k)) begin
        err_cnt++;
        $display("FAIL nb4_order[%0d]: got valid=%b bank=%0d, expected valid=1 bank=%0d",
                 k, frame_valid_4, frame_bank_4, k);
      end
      step();
    end
    frame_ready = 1'b0;
    vec_cnt++;
    if (frame_valid_4 !== 1'b0 || drop_cnt_4 !== 16'd0) begin
      err_cnt++;
      $display("FAIL nb4_drained: got valid=%b drop=%0d, expected valid=0 drop=0", frame_valid_4, drop_cnt_4);
    end
    $display("test_four_banks done: vectors=%0d", vec_cnt);
  endtask

  task automatic test_async_reset();
    apply_reset();
    frame_len_m1 = 11'd7; run = 1'b1;
    step();
    for (int i = 0; i < 6; i++) do_tick(12'(32 + i));
    vec_cnt++;
    if (wr_en !== 2'b01 || wr_addr !== 11'd5) begin
      err_cnt++;
      $display("FAIL arst_pre: got en=%b addr=%0d, expected en=01 addr=5", wr_en, wr_addr);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({wr_en, wr_addr, wr_data, frame_valid, frame_bank, frame_done, drop_cnt, overrun_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL arst_immediate: got en=%b addr=%0d data=%h v=%b, expected all 0",
               wr_en, wr_addr, wr_data, frame_valid);
    end
    step();
    rst = 1'b0;
    step();
    do_tick(12'h5A5);
    vec_cnt++;
    if (wr_en !== 2'b01 || wr_addr !== 11'd0 || wr_data !== 12'h5A5) begin
      err_cnt++;
      $display("FAIL arst_restart: got en=%b addr=%0d data=%h, expected en=01 addr=0 data=5a5",
               wr_en, wr_addr, wr_data);
    end
    $display("test_async_reset done: vectors=%0d", vec_cnt);
  endtask

  task automatic test_abort_saturate();
    apply_reset();
    frame_len_m1 = 11'd3; run = 1'b1;
    step();
    for (int i = 0; i < 8; i++) do_tick(12'(64 + i));
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) do_tick(12'(80 + i));
    vec_cnt++;
    if (wr_en !== 2'b01 || wr_addr !== 11'd2) begin
      err_cnt++;
      $display("FAIL abort_pre: got en=%b addr=%0d, expected en=01 addr=2", wr_en, wr_addr);
    end
    run = 1'b0;
    step();
    vec_cnt++;
    if (frame_valid !== 1'b1 || frame_bank !== 1'b1 || wr_en !== 2'b00) begin
      err_cnt++;
      $display("FAIL abort_keep_full: got valid=%b bank=%0d en=%b, expected valid=1 bank=1 en=00",
               frame_valid, frame_bank, wr_en);
    end
    run = 1'b1;
    step();
    do_tick(12'h777);
    vec_cnt++;
    if (wr_en !== 2'b01 || wr_addr !== 11'd0) begin
      err_cnt++;
      $display("FAIL abort_restart: got en=%b addr=%0d, expected en=01 addr=0", wr_en, wr_addr);
    end
    for (int i = 0; i < 3; i++) do_tick(12'(96 + i));
    vec_cnt++;
    if (frame_done !== 1'b1 || wr_addr !== 11'd3) begin
      err_cnt++;
      $display("FAIL abort_refill: got done=%b addr=%0d, expected done=1 addr=3", frame_done, wr_addr);
    end
    sample_tick = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    vec_cnt++;
    if (drop_cnt !== 16'd10 || wr_en !== 2'b00) begin
      err_cnt++;
      $display("FAIL sat_count: got drop=%0d en=%b, expected drop=10 en=00", drop_cnt, wr_en);
    end
    repeat (65530) @(posedge clk);
    #1;
    sample_tick = 1'b0;
    vec_cnt++;
    if (drop_cnt !== 16'hFFFF || overrun_cnt !== 16'd0) begin
      err_cnt++;
      $display("FAIL sat_limit: got drop=%h ovr=%0d, expected drop=ffff ovr=0", drop_cnt, overrun_cnt);
    end
    $display("test_abort_saturate done: vectors=%0d", vec_cnt);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_overwrite();
    test_four_banks();
    test_async_reset();
    test_abort_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
